swizzle_cram_to_dram: RTL

- Unload path, the counterpart of the DRAM-to-CRAM load swizzle.
- Reads bit-serial (transposed) data out of compute RAM, re-transposes each DWIDTH x DWIDTH bit block in a ping-pong buffer, and streams word-parallel data to the memory controller.
- Sits between the CRAM read port and the DMA/memory-controller write channel.
- Address pattern is the exact inverse of the load path, so a load followed by an unload returns the original data.

---
 rtl/swizzle_cram_to_dram_pkg.sv | 18 +
 rtl/swizzle_cram_to_dram_transpose_buffer.sv | 35 +++
 rtl/swizzle_cram_to_dram.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/swizzle_cram_to_dram_pkg.sv
// Shared constants for the CRAM<->DRAM swizzle paths.
// Holds the default geometry (also used by the load-side swizzle) and the
// state encodings of the unload read and write FSMs.
package swizzle_cram_to_dram_pkg;
  localparam int SWZ_DWIDTH        = 40;
  localparam int SWZ_ADDR_WIDTH    = 13;
  localparam int SWZ_ADDR_STRIDE   = 4;
  localparam int SWZ_BLK_CNT_WIDTH = 8;

  // Read FSM: issues CRAM reads into the current fill buffer
  localparam logic [1:0] RD_IDLE  = 2'd0;
  localparam logic [1:0] RD_ISSUE = 2'd1;
  localparam logic [1:0] RD_WAIT  = 2'd2;

  // Write FSM: drains the oldest full buffer to the memory controller
  localparam logic [0:0] WR_IDLE  = 1'b0;
  localparam logic [0:0] WR_DRAIN = 1'b1;
endpackage

// File: rtl/swizzle_cram_to_dram_transpose_buffer.sv
// swizzle_transpose_buffer: one DWIDTH x DWIDTH bit block.
// Ports:
//   clk              clock
//   wr_en/wr_row     row write: word k read from CRAM lands in row k
//   wr_data          row data
//   rd_col           output word index j
//   rd_data          column read, bit k = row k bit (DWIDTH-1-j)
module swizzle_transpose_buffer
  import swizzle_cram_to_dram_pkg::*;
#(
  parameter  int DWIDTH = SWZ_DWIDTH,
  localparam int IW     = $clog2(DWIDTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_row,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic [IW-1:0]     rd_col,
  output logic [DWIDTH-1:0] rd_data
);
  logic [DWIDTH-1:0] mem [DWIDTH];
  logic [IW-1:0]     src_bit;

  // Output word 0 takes the MSB of every row
  assign src_bit = IW'(DWIDTH - 1) - rd_col;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_row] <= wr_data;
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < DWIDTH; k++) rd_data[k] = mem[k][src_bit];
  end
endmodule

// File: rtl/swizzle_cram_to_dram.sv
// swizzle_cram_to_dram: CRAM unload path. Reads bit-serial blocks out of
// compute RAM, re-transposes them through a ping/pong pair of buffers and
// streams word-parallel data to the memory controller.
// Ports:
//   clk, reset                    clock, async active-high reset
//   start/ram_start_addr/num_blocks  transfer request (sampled in idle)
//   ram_addr/ram_re/ram_data_in   CRAM read port (1-cycle read latency)
//   mem_ctrl_data_out/_valid/_last, mem_ctrl_ready   output stream
//   busy, done                    transfer status
module swizzle_cram_to_dram
  import swizzle_cram_to_dram_pkg::*;
#(
  parameter int DWIDTH        = SWZ_DWIDTH,
  parameter int ADDR_WIDTH    = SWZ_ADDR_WIDTH,
  parameter int ADDR_STRIDE   = SWZ_ADDR_STRIDE,
  parameter int BLK_CNT_WIDTH = SWZ_BLK_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    ram_start_addr,
  input  logic [BLK_CNT_WIDTH-1:0] num_blocks,
  output logic [ADDR_WIDTH-1:0]    ram_addr,
  output logic                     ram_re,
  input  logic [DWIDTH-1:0]        ram_data_in,
  output logic [DWIDTH-1:0]        mem_ctrl_data_out,
  output logic                     mem_ctrl_data_valid,
  input  logic                     mem_ctrl_ready,
  output logic                     mem_ctrl_data_last,
  output logic                     busy,
  output logic                     done
);
  localparam int            IW   = $clog2(DWIDTH);
  localparam logic [IW-1:0] LAST = IW'(DWIDTH - 1);
  localparam logic [BLK_CNT_WIDTH-1:0] ONE_BLK = BLK_CNT_WIDTH'(1);

  logic [1:0]               rd_state;
  logic [IW-1:0]            rd_k;
  logic                     fill_buf;
  logic [BLK_CNT_WIDTH-1:0] rd_blk_left;
  logic [ADDR_WIDTH-1:0]    blk_base;

  logic                     cap_vld, cap_buf;
  logic [IW-1:0]            cap_row;

  logic [1:0]               full, set_full, freeing, buf_free;
  logic [0:0]               wr_state;
  logic                     wr_buf;
  logic [IW-1:0]            wr_j;
  logic [BLK_CNT_WIDTH-1:0] wr_blk_left;
  logic [1:0][DWIDTH-1:0]   col_data;
  logic                     accept, start_ok;

  assign start_ok = start && (rd_state == RD_IDLE) && !busy;
  assign accept   = (wr_state == WR_DRAIN) && mem_ctrl_ready;

  // A buffer counts as free in the cycle its last word is accepted: the
  // first row write of a new block lands one cycle after its ram_re, by
  // which time the drain has moved on. This keeps output gapless.
  always_comb begin
    set_full = '0;
    freeing  = '0;
    buf_free = '0;
    for (int b = 0; b < 2; b++) begin
      set_full[b] = cap_vld && (cap_buf == 1'(b)) && (cap_row == LAST);
      freeing[b]  = accept && (wr_buf == 1'(b)) && (wr_j == LAST);
      buf_free[b] = !full[b] || freeing[b];
    end
  end

  assign ram_re = (rd_state == RD_ISSUE) ||
                  ((rd_state == RD_WAIT) && buf_free[fill_buf]);

  // Read FSM. fill_buf flips at the end of every block, so in RD_WAIT it
  // already names the buffer the next block will fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state    <= RD_IDLE;
      rd_k        <= '0;
      fill_buf    <= 1'b0;
      rd_blk_left <= '0;
      ram_addr    <= '0;
      blk_base    <= '0;
    end else if (start_ok && (num_blocks != '0)) begin
      rd_state    <= RD_ISSUE;
      rd_k        <= '0;
      fill_buf    <= 1'b0;
      rd_blk_left <= num_blocks;
      ram_addr    <= ram_start_addr;
      blk_base    <= ram_start_addr;
    end else if (ram_re) begin
      if (rd_k != LAST) begin
        rd_k     <= rd_k + IW'(1);
        ram_addr <= ram_addr + ADDR_WIDTH'(ADDR_STRIDE);
        rd_state <= RD_ISSUE;
      end else begin
        rd_k        <= '0;
        fill_buf    <= ~fill_buf;
        ram_addr    <= blk_base + ADDR_WIDTH'(1);
        blk_base    <= blk_base + ADDR_WIDTH'(1);
        rd_blk_left <= rd_blk_left - ONE_BLK;
        if (rd_blk_left == ONE_BLK)  rd_state <= RD_IDLE;
        else if (buf_free[~fill_buf]) rd_state <= RD_ISSUE;
        else                          rd_state <= RD_WAIT;
      end
    end
  end

  // Read data returns one cycle after ram_re; tag it with its slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_vld <= 1'b0;
      cap_buf <= 1'b0;
      cap_row <= '0;
    end else begin
      cap_vld <= ram_re;
      cap_buf <= fill_buf;
      cap_row <= rd_k;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) full <= '0;
    else       full <= (full & ~freeing) | set_full;
  end

  // Write FSM. The set_full terms let a just-completed buffer start
  // draining with no extra cycle of latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state    <= WR_IDLE;
      wr_buf      <= 1'b0;
      wr_j        <= '0;
      wr_blk_left <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_ok) begin
        if (num_blocks != '0) begin
          busy        <= 1'b1;
          wr_blk_left <= num_blocks;
          wr_buf      <= 1'b0;
          wr_j        <= '0;
        end else begin
          done <= 1'b1;
        end
      end
      case (wr_state)
        WR_IDLE: begin
          if (full[wr_buf] || set_full[wr_buf]) wr_state <= WR_DRAIN;
        end
        default: begin
          if (mem_ctrl_ready) begin
            if (wr_j != LAST) begin
              wr_j <= wr_j + IW'(1);
            end else begin
              wr_j        <= '0;
              wr_buf      <= ~wr_buf;
              wr_blk_left <= wr_blk_left - ONE_BLK;
              if (wr_blk_left == ONE_BLK) begin
                wr_state <= WR_IDLE;
                busy     <= 1'b0;
                done     <= 1'b1;
              end else if (!(full[~wr_buf] || set_full[~wr_buf])) begin
                wr_state <= WR_IDLE;
              end
            end
          end
        end
      endcase
    end
  end

  swizzle_transpose_buffer #(.DWIDTH(DWIDTH)) u_ping (
    .clk     (clk),
    .wr_en   (cap_vld && !cap_buf),
    .wr_row  (cap_row),
    .wr_data (ram_data_in),
    .rd_col  (wr_j),
    .rd_data (col_data[0])
  );

  swizzle_transpose_buffer #(.DWIDTH(DWIDTH)) u_pong (
    .clk     (clk),
    .wr_en   (cap_vld && cap_buf),
    .wr_row  (cap_row),
    .wr_data (ram_data_in),
    .rd_col  (wr_j),
    .rd_data (col_data[1])
  );

  // Buffer contents are not reset, so gate the data with valid
  assign mem_ctrl_data_valid = (wr_state == WR_DRAIN);
  assign mem_ctrl_data_out   = mem_ctrl_data_valid ? col_data[wr_buf] : '0;
  assign mem_ctrl_data_last  = mem_ctrl_data_valid && (wr_j == LAST) &&
                               (wr_blk_left == ONE_BLK);
endmodule
